// File: rtl/aging_uart_pkg.sv
// Shared encodings for the aging-sensor UART streamer: FSM states, hold
// bookkeeping and the fixed framing constants.
package aging_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SNAP,
        ST_SOF,
        ST_CHDR,
        ST_NIB,
        ST_CSUM,
        ST_HOLD,
        ST_GAP
    } state_e;

    // Remembers which byte HOLD is waiting on, so HOLD knows where to go next.
    typedef enum logic [1:0] {
        HK_SOF,
        HK_HDR,
        HK_NIB,
        HK_CSUM
    } hold_kind_e;

    localparam logic [7:0] SOF_BYTE = 8'hA5;
    localparam logic [3:0] HDR_NIB  = 4'hC;

endpackage

// File: rtl/aging_uart_streamer.sv
// Snapshots aging-sensor channel words and streams them to a byte UART as
// framed, nibble-indexed bytes followed by an XOR checksum.
module aging_uart_streamer
    import aging_uart_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int DATA_W  = 20,
    parameter int GAP_CYC = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*DATA_W-1:0] data_i,
    input  logic [NUM_CH-1:0]        ch_en_i,
    input  logic                     cont_i,
    input  logic                     start_i,
    input  logic                     uart_busy_i,
    output logic [7:0]               tx_data_o,
    output logic                     tx_valid_o,
    output logic                     snap_o,
    output logic                     frame_done_o,
    output logic                     busy_o
);

    localparam int NIB_CNT = DATA_W / 4;
    localparam int GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    state_e                    state_q;
    hold_kind_e                kind_q;
    logic                      hold_first_q;
    logic                      cont_q;
    logic [NUM_CH*DATA_W-1:0]  shadow_q;
    logic [NUM_CH-1:0]         mask_q;
    logic [7:0]                csum_q;
    logic [3:0]                ch_q;
    logic [3:0]                nib_q;
    logic [GAP_W-1:0]          gap_q;
    logic [7:0]                tx_data_q;
    logic                      tx_valid_q;
    logic                      snap_q;
    logic                      done_q;
    logic                      busy_q;

    logic [DATA_W-1:0] cur_word;
    logic [3:0]        cur_nib;
    logic [7:0]        hdr_byte;
    logic [7:0]        nib_byte;
    logic [3:0]        first_ch;
    logic [3:0]        next_ch;
    logic              next_found;
    logic              gap_last;

    // Byte sources are indexed muxes over the shadow; next-channel search
    // scans downward so the lowest qualifying index wins.
    always_comb begin
        cur_word   = shadow_q[int'(ch_q)*DATA_W +: DATA_W];
        cur_nib    = cur_word[int'(nib_q)*4 +: 4];
        hdr_byte   = {HDR_NIB, ch_q};
        nib_byte   = {nib_q, cur_nib};
        first_ch   = 4'd0;
        next_ch    = 4'd0;
        next_found = 1'b0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (mask_q[k]) begin
                first_ch = 4'(k);
                if (4'(k) > ch_q) begin
                    next_ch    = 4'(k);
                    next_found = 1'b1;
                end
            end
        end
        gap_last = (int'(gap_q) >= GAP_CYC - 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            kind_q       <= HK_SOF;
            hold_first_q <= 1'b0;
            cont_q       <= 1'b0;
            shadow_q     <= '0;
            mask_q       <= '0;
            csum_q       <= 8'h00;
            ch_q         <= 4'd0;
            nib_q        <= 4'd0;
            gap_q        <= '0;
            tx_data_q    <= 8'h00;
            tx_valid_q   <= 1'b0;
            snap_q       <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            tx_valid_q <= 1'b0;
            snap_q     <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if ((start_i || cont_i) && (ch_en_i != '0)) begin
                        cont_q  <= cont_i;
                        busy_q  <= 1'b1;
                        state_q <= ST_SNAP;
                    end
                end
                ST_SNAP: begin
                    shadow_q <= data_i;
                    mask_q   <= ch_en_i;
                    csum_q   <= 8'h00;
                    ch_q     <= 4'd0;
                    nib_q    <= 4'd0;
                    snap_q   <= 1'b1;
                    state_q  <= ST_SOF;
                end
                ST_SOF: begin
                    if (!uart_busy_i) begin
                        tx_data_q    <= SOF_BYTE;
                        tx_valid_q   <= 1'b1;
                        hold_first_q <= 1'b1;
                        kind_q       <= HK_SOF;
                        state_q      <= ST_HOLD;
                    end
                end
                ST_CHDR: begin
                    if (!uart_busy_i) begin
                        tx_data_q    <= hdr_byte;
                        tx_valid_q   <= 1'b1;
                        csum_q       <= csum_q ^ hdr_byte;
                        hold_first_q <= 1'b1;
                        kind_q       <= HK_HDR;
                        state_q      <= ST_HOLD;
                    end
                end
                ST_NIB: begin
                    if (!uart_busy_i) begin
                        tx_data_q    <= nib_byte;
                        tx_valid_q   <= 1'b1;
                        csum_q       <= csum_q ^ nib_byte;
                        hold_first_q <= 1'b1;
                        kind_q       <= HK_NIB;
                        state_q      <= ST_HOLD;
                    end
                end
                ST_CSUM: begin
                    if (!uart_busy_i) begin
                        tx_data_q    <= csum_q;
                        tx_valid_q   <= 1'b1;
                        hold_first_q <= 1'b1;
                        kind_q       <= HK_CSUM;
                        state_q      <= ST_HOLD;
                    end
                end
                // The first HOLD cycle ignores busy: the UART may not have
                // raised it yet for the byte just strobed.
                ST_HOLD: begin
                    if (hold_first_q) begin
                        hold_first_q <= 1'b0;
                    end else if (!uart_busy_i) begin
                        case (kind_q)
                            HK_SOF: begin
                                ch_q    <= first_ch;
                                nib_q   <= 4'd0;
                                state_q <= ST_CHDR;
                            end
                            HK_HDR: begin
                                nib_q   <= 4'd0;
                                state_q <= ST_NIB;
                            end
                            HK_NIB: begin
                                if (nib_q == 4'(NIB_CNT - 1)) begin
                                    nib_q <= 4'd0;
                                    if (next_found) begin
                                        ch_q    <= next_ch;
                                        state_q <= ST_CHDR;
                                    end else begin
                                        state_q <= ST_CSUM;
                                    end
                                end else begin
                                    nib_q   <= nib_q + 4'd1;
                                    state_q <= ST_NIB;
                                end
                            end
                            default: begin
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                gap_q   <= '0;
                                state_q <= cont_q ? ST_GAP : ST_IDLE;
                            end
                        endcase
                    end
                end
                ST_GAP: begin
                    if (gap_last) begin
                        gap_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_data_o    = tx_data_q;
    assign tx_valid_o   = tx_valid_q;
    assign snap_o       = snap_q;
    assign frame_done_o = done_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_aging_uart_streamer.sv
// Directed bench for the aging UART streamer: a small 2x8-bit instance for
// framing/reset/continuous cases and a default-parameter instance under a slow UART.
module tb_aging_uart_streamer;

    logic clk;
    logic rst;

    logic [15:0] s_data;
    logic [1:0]  s_en;
    logic        s_cont, s_start, s_ubusy;
    logic [7:0]  s_tx_data;
    logic        s_tx_valid, s_snap, s_done, s_busy;

    logic [39:0] d_data;
    logic [1:0]  d_en;
    logic        d_cont, d_start, d_ubusy;
    logic [7:0]  d_tx_data;
    logic        d_tx_valid, d_snap, d_done, d_busy;

    logic [7:0] s_exp_q[$];
    logic [7:0] d_exp_q[$];

    int checks;
    int errors;
    int s_strobes, s_snaps, d_strobes;
    logic d_busy_seen;

    aging_uart_streamer #(.NUM_CH(2), .DATA_W(8), .GAP_CYC(16)) u_small (
        .clk(clk), .rst(rst), .data_i(s_data), .ch_en_i(s_en), .cont_i(s_cont),
        .start_i(s_start), .uart_busy_i(s_ubusy), .tx_data_o(s_tx_data),
        .tx_valid_o(s_tx_valid), .snap_o(s_snap), .frame_done_o(s_done), .busy_o(s_busy)
    );

    aging_uart_streamer u_dflt (
        .clk(clk), .rst(rst), .data_i(d_data), .ch_en_i(d_en), .cont_i(d_cont),
        .start_i(d_start), .uart_busy_i(d_ubusy), .tx_data_o(d_tx_data),
        .tx_valid_o(d_tx_valid), .snap_o(d_snap), .frame_done_o(d_done), .busy_o(d_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_model(input bit to_d, input int nch, input int dw,
                              input logic [63:0] data, input logic [7:0] mask);
        logic [7:0] b;
        logic [7:0] cs;
        cs = 8'h00;
        if (to_d) d_exp_q.push_back(8'hA5); else s_exp_q.push_back(8'hA5);
        for (int ch = 0; ch < nch; ch++) begin
            if (mask[ch]) begin
                b = {4'hC, 4'(ch)};
                cs ^= b;
                if (to_d) d_exp_q.push_back(b); else s_exp_q.push_back(b);
                for (int n = 0; n < dw / 4; n++) begin
                    b = {4'(n), data[ch*dw + n*4 +: 4]};
                    cs ^= b;
                    if (to_d) d_exp_q.push_back(b); else s_exp_q.push_back(b);
                end
            end
        end
        if (to_d) d_exp_q.push_back(cs); else s_exp_q.push_back(cs);
    endtask

    // Scoreboard monitors: pop one expected byte per strobe.
    always @(negedge clk) begin
        if (s_tx_valid) begin
            s_strobes++;
            if (s_exp_q.size() == 0) check("s_unexpected_strobe", {24'h0, s_tx_data}, 32'h1ff);
            else check("s_byte", {24'h0, s_tx_data}, {24'h0, s_exp_q.pop_front()});
        end
        if (s_snap) s_snaps++;
    end

    always @(posedge clk) d_busy_seen <= d_ubusy;

    always @(negedge clk) begin
        if (d_tx_valid) begin
            d_strobes++;
            check("d_no_strobe_while_busy", {31'h0, d_busy_seen}, 32'h0);
            if (d_exp_q.size() == 0) check("d_unexpected_strobe", {24'h0, d_tx_data}, 32'h1ff);
            else check("d_byte", {24'h0, d_tx_data}, {24'h0, d_exp_q.pop_front()});
        end
    end

    // Slow UART for the default instance: busy for 50 cycles after each strobe.
    initial begin
        d_ubusy = 1'b0;
        forever begin
            @(negedge clk);
            if (d_tx_valid) begin
                d_ubusy = 1'b1;
                repeat (50) @(negedge clk);
                d_ubusy = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

    task automatic pulse_s_start();
        @(negedge clk); s_start = 1'b1;
        @(negedge clk); s_start = 1'b0;
    endtask

    task automatic wait_s_done(input string tag, input int budget);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge clk);
            if (s_done) seen = 1'b1;
        end
        check(tag, {31'h0, seen}, 32'h1);
    endtask

    task automatic wait_d_done(input string tag, input int budget);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge clk);
            if (d_done) seen = 1'b1;
        end
        check(tag, {31'h0, seen}, 32'h1);
    endtask

    task automatic check_s_zero(input string tag);
        check({tag, "_tx_data"}, {24'h0, s_tx_data}, 32'h0);
        check({tag, "_tx_valid"}, {31'h0, s_tx_valid}, 32'h0);
        check({tag, "_snap"}, {31'h0, s_snap}, 32'h0);
        check({tag, "_done"}, {31'h0, s_done}, 32'h0);
        check({tag, "_busy"}, {31'h0, s_busy}, 32'h0);
    endtask

    initial begin
        int base, snaps0, n, k;
        logic [39:0] rnd;
        checks = 0; errors = 0;
        s_strobes = 0; s_snaps = 0; d_strobes = 0;
        s_data = 16'h0; s_en = 2'b00; s_cont = 1'b0; s_start = 1'b0; s_ubusy = 1'b0;
        d_data = 40'h0; d_en = 2'b00; d_cont = 1'b0; d_start = 1'b0;

        // Reset state
        rst = 1'b1;
        #1;
        check_s_zero("reset_s");
        check("reset_d_tx_data", {24'h0, d_tx_data}, 32'h0);
        check("reset_d_busy", {31'h0, d_busy}, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Both channels enabled, idle UART
        s_data = 16'h5A3C; s_en = 2'b11;
        s_exp_q = {8'hA5, 8'hC0, 8'h0C, 8'h13, 8'hC1, 8'h0A, 8'h15, 8'h01};
        base = s_strobes; snaps0 = s_snaps;
        pulse_s_start();
        wait_s_done("a_done", 200);
        check("a_queue_empty", s_exp_q.size(), 0);
        check("a_strobes", s_strobes - base, 8);
        check("a_snaps", s_snaps - snaps0, 1);
        check("a_busy_after", {31'h0, s_busy}, 32'h0);

        // Channel 0 disabled: skipped entirely
        s_en = 2'b10;
        s_exp_q = {8'hA5, 8'hC1, 8'h0A, 8'h15, 8'hDE};
        base = s_strobes;
        pulse_s_start();
        wait_s_done("b_done", 200);
        check("b_queue_empty", s_exp_q.size(), 0);
        check("b_strobes", s_strobes - base, 5);

        // Inputs change after the snapshot; frame keeps the captured values
        s_data = 16'hE7B2; s_en = 2'b11;
        push_model(1'b0, 2, 8, 64'(16'hE7B2), 8'h03);
        pulse_s_start();
        k = 0;
        for (n = 0; n < 20 && k == 0; n++) begin
            @(negedge clk);
            if (s_snap) k = 1;
        end
        check("c_snap_seen", k, 1);
        s_data = 16'hFFFF; s_en = 2'b01; s_start = 1'b1;
        @(negedge clk); s_start = 1'b0;
        wait_s_done("c_done", 200);
        check("c_queue_empty", s_exp_q.size(), 0);

        // Continuous mode: two frames separated by the gap
        s_data = 16'h1234; s_en = 2'b11; s_cont = 1'b1;
        push_model(1'b0, 2, 8, 64'(16'h1234), 8'h03);
        push_model(1'b0, 2, 8, 64'(16'h1234), 8'h03);
        wait_s_done("d_frame1_done", 200);
        n = 0;
        while (!s_tx_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        s_cont = 1'b0;
        check("d_gap_at_least_16", {31'h0, (n >= 16)}, 32'h1);
        wait_s_done("d_frame2_done", 200);
        check("d_queue_empty", s_exp_q.size(), 0);
        base = s_strobes;
        repeat (40) @(negedge clk);
        check("d_stopped", s_strobes - base, 0);

        // Zero mask never leaves IDLE
        s_en = 2'b00; s_cont = 1'b1; s_start = 1'b1;
        base = s_strobes;
        repeat (100) @(negedge clk);
        check("e_zero_mask_strobes", s_strobes - base, 0);
        check("e_zero_mask_busy", {31'h0, s_busy}, 32'h0);
        s_cont = 1'b0; s_start = 1'b0;
        @(negedge clk);

        // Reset after the third byte aborts the frame
        s_data = 16'h9E71; s_en = 2'b11;
        push_model(1'b0, 2, 8, 64'(16'h9E71), 8'h03);
        pulse_s_start();
        k = 0;
        for (n = 0; n < 100 && k < 3; n++) begin
            @(negedge clk);
            if (s_tx_valid) k++;
        end
        check("f_three_bytes", k, 3);
        #1 rst = 1'b1;
        #1;
        check_s_zero("f_reset");
        s_exp_q.delete();
        base = s_strobes;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("f_no_strobe_after_reset", s_strobes - base, 0);
        push_model(1'b0, 2, 8, 64'(16'h9E71), 8'h03);
        pulse_s_start();
        wait_s_done("f_restart_done", 200);
        check("f_restart_strobes", s_strobes - base, 8);
        check("f_queue_empty", s_exp_q.size(), 0);

        // Default parameters behind a slow UART
        rnd = {8'($urandom_range(0, 255)), 32'($urandom)};
        d_data = rnd; d_en = 2'b11;
        push_model(1'b1, 2, 20, 64'(rnd), 8'h03);
        base = d_strobes;
        @(negedge clk); d_start = 1'b1;
        @(negedge clk); d_start = 1'b0;
        wait_d_done("g_done", 2000);
        check("g_strobes", d_strobes - base, 14);
        check("g_queue_empty", d_exp_q.size(), 0);

        rnd = {8'($urandom_range(0, 255)), 32'($urandom)};
        d_data = rnd; d_en = 2'b01;
        push_model(1'b1, 2, 20, 64'(rnd), 8'h01);
        base = d_strobes;
        @(negedge clk); d_start = 1'b1;
        @(negedge clk); d_start = 1'b0;
        wait_d_done("h_done", 2000);
        check("h_strobes", d_strobes - base, 8);
        check("h_queue_empty", d_exp_q.size(), 0);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
